counter_chain_arbiter: RTL and testbench
========================================

Name: counter_chain_arbiter

Overview:
- Shares one counter-chain compressor instance among NREQ requesters.
- Each request beat carries four LENGTH-bit operand words plus one LENGTH-bit correction word. The block round-robin arbitrates, drives the chain inputs, and tracks each issued beat through the chain's fixed latency.
- Results return tagged with the requester ID through a credit-protected result FIFO with valid/ready backpressure.
- Sits between the operand-producing lanes and the single shared chain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LENGTH, 8, operand width per chain column group.
- LAT, 1, chain latency in cycles; 0 = combinational chain, 1 = registered-output chain.
- DEPTH, 4, result FIFO entries; must be at least LAT+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_ops  in  NREQ*5*LENGTH  per requester, packed as {cl10, cl03, cl02, cl01, cl00}.
- req_cin  in  NREQ*6  per requester, packed as {c1, c0[4:0]}.
- ch_cl00 / ch_cl01 / ch_cl02 / ch_cl03 / ch_cl10  out  LENGTH each  chain operand inputs.
- ch_c0  out  5  chain tail inputs.
- ch_c1  out  1  chain tail input.
- ch_o  in  2*LENGTH+3  chain result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  log2(NREQ) (minimum 1)  originating requester.
- rsp_data  out  2*LENGTH+3  chain result.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rr_ptr=0, in-flight pipe cleared, FIFO empty, credits=DEPTH.
  - Outputs: rsp_valid=0, req_ready=0, all ch_* outputs 0.
- Issue condition: some req_valid bit is high and credits>0.
- Grant: the first valid requester searching from rr_ptr upward, wrapping at NREQ-1 to 0. The grant is combinational.
- On issue:
  - req_ready[g]=1 for the granted requester only; the transfer is req_valid&req_ready.
  - ch_* outputs carry that requester's fields in the same cycle.
  - rr_ptr <= (g+1) mod NREQ.
  - credits decrements.
- When not issuing: ch_* outputs are forced to 0 (operand gating, no stale toggling).
- In-flight tracking:
  - LAT-stage shift register of {valid, id}.
  - Stage output valid at issue cycle + LAT; ch_o is sampled that cycle and pushed into the FIFO together with its id.
  - LAT=0: the push happens in the issue cycle.
- Result port:
  - rsp_valid = FIFO not empty; rsp_data/rsp_id come from the FIFO head.
  - The first response appears at issue + LAT + 1.
  - Back-to-back issue gives one result per cycle.
- Credits:
  - Decrement on issue, increment on rsp_valid&rsp_ready.
  - Simultaneous issue and pop leaves the count unchanged.
  - credits=0 blocks all grants, so no FIFO overflow is possible even with rsp_ready held low indefinitely.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Push while full is impossible by construction; assertion required.
  - Pop and push in the same cycle are legal at any occupancy, including empty when LAT=0 (a fall-through path is not required).
- rsp_data, rsp_id and rsp_valid stay stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: in-flight beats and FIFO contents are discarded, and no response is emitted after deassertion.
- Single-requester case: that requester is granted every cycle while credits allow.

Optional Feature:
- Macro: COUNTER_CHAIN_ARB_LOCK_EN.
- With the macro defined:
  - Adds input req_lock[NREQ].
  - If the last granted requester issued with req_lock=1, it keeps priority on the next issue opportunity: rr_ptr is not advanced and grant is forced to it while its req_valid is high.
  - Lock releases on a beat issued with req_lock=0, or when that requester's req_valid drops.
- Without the macro: the port is absent and behaviour is pure round-robin.

Decomposition:
- Shared package counter_chain_pkg holds:
  - function clog2_min1;
  - typedef for the per-requester field struct {cl10, cl03, cl02, cl01, cl00, c1, c0};
  - constant OW(LENGTH) = 2*LENGTH+3.
- One natural sub-module: counter_chain_rsp_fifo, a parameterised circular FIFO of {id, data} with full/empty/count.
- Arbitration and credit logic stay in the top module.

Test Plan:
- NREQ=4, LAT=1, all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0...; rsp_id sequence matches, first rsp_valid at cycle 2 after first issue.
- Only requester 2 valid with cl00=8'h0F and other fields 0 -> ch_cl00=8'h0F during the grant cycle, ch_* = 0 in idle cycles, response id=2 with data equal to the chain model output.
- rsp_ready=0, DEPTH=4, requesters always valid -> exactly 4 issues then req_ready=0; raising rsp_ready for 1 cycle -> exactly one further issue.
- FIFO wrap: 20 beats with rsp_ready toggling every cycle -> responses in issue order with no loss or duplication, credits never negative.
- Reset pulled low with 2 beats in flight and 1 in the FIFO -> rsp_valid=0 immediately; after release no stale response, rr_ptr=0.
- With COUNTER_CHAIN_ARB_LOCK_EN defined, requester 1 issues 3 beats with req_lock=1,1,0 while requesters 0 and 3 are valid -> grants 1,1,1,3,0.

Source files
------------

// File: rtl/counter_chain_pkg.sv
// rtl/counter_chain_pkg.sv - shared types, widths and helpers for the counter-chain arbiter
//
// Purpose: common definitions used by counter_chain_arbiter and its response FIFO.
//   clog2_min1  : ceil(log2(n)), never less than 1 (for id/pointer widths)
//   ow          : chain result width for a given operand width, 2*LENGTH+3
//   cc_fields_t : one requester beat at the default operand width CC_LENGTH
package counter_chain_pkg;

  localparam int CC_LENGTH = 8;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ow(input int length);
    return 2 * length + 3;
  endfunction

  // Field order matches the packed request buses: ops {cl10..cl00}, cin {c1, c0}.
  typedef struct packed {
    logic [CC_LENGTH-1:0] cl10;
    logic [CC_LENGTH-1:0] cl03;
    logic [CC_LENGTH-1:0] cl02;
    logic [CC_LENGTH-1:0] cl01;
    logic [CC_LENGTH-1:0] cl00;
    logic                 c1;
    logic [4:0]           c0;
  } cc_fields_t;

endpackage

// File: rtl/counter_chain_rsp_fifo.sv
// rtl/counter_chain_rsp_fifo.sv - circular FIFO holding tagged chain results
//
// Purpose: DEPTH-entry circular buffer with wrap-around pointers; head entry is
// presented combinationally on o_pop_data.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_push/i_push_data write one entry
//   i_pop              remove head entry (ignored when empty)
//   o_pop_data         head entry
//   o_full/o_empty     occupancy flags
//   o_count            number of stored entries
module counter_chain_rsp_fifo
  import counter_chain_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [DW-1:0]                 i_push_data,
  input  logic                          i_pop,
  output logic [DW-1:0]                 o_pop_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH+1)-1:0]    o_count
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (i_push && !w_do_pop) r_count <= r_count + CW'(1);
      else if (!i_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // The credit scheme upstream guarantees there is always a free slot for a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));

endmodule

// File: rtl/counter_chain_arbiter.sv
// rtl/counter_chain_arbiter.sv - round-robin sharing of one counter-chain compressor
//
// Purpose: grants one of NREQ requesters per cycle (credit permitting), drives the
// shared chain with its fields, tracks the beat through LAT chain stages and returns
// the result tagged with the requester id through a credit-protected FIFO.
// Optional feature macro: COUNTER_CHAIN_ARB_LOCK_EN adds req_lock (sticky priority).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake (one-hot ready)
//   req_ops                     per requester {cl10, cl03, cl02, cl01, cl00}
//   req_cin                     per requester {c1, c0[4:0]}
//   req_lock                    (lock build only) keep priority after this beat
//   ch_cl00..ch_cl10, ch_c0/c1  chain inputs, zero when not issuing
//   ch_o                        chain result, valid LAT cycles after issue
//   rsp_valid/rsp_ready         result handshake
//   rsp_id/rsp_data             originating requester and chain result
module counter_chain_arbiter
  import counter_chain_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LENGTH = 8,
  parameter int LAT    = 1,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*5*LENGTH-1:0]     req_ops,
  input  logic [NREQ*6-1:0]            req_cin,
`ifdef COUNTER_CHAIN_ARB_LOCK_EN
  input  logic [NREQ-1:0]              req_lock,
`endif
  output logic [LENGTH-1:0]            ch_cl00,
  output logic [LENGTH-1:0]            ch_cl01,
  output logic [LENGTH-1:0]            ch_cl02,
  output logic [LENGTH-1:0]            ch_cl03,
  output logic [LENGTH-1:0]            ch_cl10,
  output logic [4:0]                   ch_c0,
  output logic                         ch_c1,
  input  logic [ow(LENGTH)-1:0]        ch_o,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [clog2_min1(NREQ)-1:0]  rsp_id,
  output logic [ow(LENGTH)-1:0]        rsp_data
);

  localparam int IDW = clog2_min1(NREQ);
  localparam int OWD = ow(LENGTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0]      r_rr_ptr;
  logic [CW-1:0]       r_credits;
  logic                w_any;
  logic [IDW-1:0]      w_grant;
  logic                w_issue;
  logic                w_hold_ptr;
  logic                w_pop;
  logic                w_push;
  logic [IDW-1:0]      w_push_id;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [CW-1:0]       w_fifo_count;
  logic [5*LENGTH-1:0] w_ops [NREQ];
  logic [5:0]          w_cin [NREQ];

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_ops[i] = req_ops[i*5*LENGTH +: 5*LENGTH];
    assign w_cin[i] = req_cin[i*6 +: 6];
  end

`ifdef COUNTER_CHAIN_ARB_LOCK_EN
  logic           r_lock_active;
  logic [IDW-1:0] r_lock_id;
`endif

  // First valid requester at or after rr_ptr, wrapping; a held lock overrides.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_any   = 1'b1;
        w_grant = wrap_add(r_rr_ptr, k);
      end
    end
`ifdef COUNTER_CHAIN_ARB_LOCK_EN
    if (r_lock_active && req_valid[r_lock_id]) w_grant = r_lock_id;
`endif
  end

  // rst_n gating keeps the handshake and chain inputs quiet while reset is held.
  assign w_issue   = rst_n && w_any && (r_credits != '0);
  assign req_ready = w_issue ? (NREQ'(1) << w_grant) : '0;

`ifdef COUNTER_CHAIN_ARB_LOCK_EN
  assign w_hold_ptr = req_lock[w_grant];
`else
  assign w_hold_ptr = 1'b0;
`endif

  // Operand gating: the chain sees zeros on every non-issue cycle.
  always_comb begin
    {ch_cl10, ch_cl03, ch_cl02, ch_cl01, ch_cl00} = '0;
    {ch_c1, ch_c0} = '0;
    if (w_issue) begin
      {ch_cl10, ch_cl03, ch_cl02, ch_cl01, ch_cl00} = w_ops[w_grant];
      {ch_c1, ch_c0} = w_cin[w_grant];
    end
  end

  assign rsp_valid = !w_fifo_empty;
  assign w_pop     = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_credits <= CW'(DEPTH);
    end else begin
      if (w_issue && !w_pop) r_credits <= r_credits - CW'(1);
      else if (!w_issue && w_pop) r_credits <= r_credits + CW'(1);
      if (w_issue && !w_hold_ptr) r_rr_ptr <= wrap_add(w_grant, 1);
    end
  end

`ifdef COUNTER_CHAIN_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_active <= 1'b0;
      r_lock_id     <= '0;
    end else if (w_issue) begin
      r_lock_active <= req_lock[w_grant];
      r_lock_id     <= w_grant;
    end else if (r_lock_active && !req_valid[r_lock_id]) begin
      r_lock_active <= 1'b0;
    end
  end
`endif

  // In-flight tracking: the id travels alongside the beat so it meets ch_o on exit.
  if (LAT == 0) begin : g_lat0
    assign w_push    = w_issue;
    assign w_push_id = w_grant;
  end else begin : g_latn
    logic [LAT-1:0] r_pipe_v;
    logic [IDW-1:0] r_pipe_id [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pipe_v <= '0;
        for (int i = 0; i < LAT; i++) r_pipe_id[i] <= '0;
      end else begin
        r_pipe_v[0]  <= w_issue;
        r_pipe_id[0] <= w_grant;
        for (int i = 1; i < LAT; i++) begin
          r_pipe_v[i]  <= r_pipe_v[i-1];
          r_pipe_id[i] <= r_pipe_id[i-1];
        end
      end
    end

    assign w_push    = r_pipe_v[LAT-1];
    assign w_push_id = r_pipe_id[LAT-1];
  end

  counter_chain_rsp_fifo #(
    .DW    (IDW + OWD),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({w_push_id, ch_o}),
    .i_pop       (w_pop),
    .o_pop_data  ({rsp_id, rsp_data}),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  a_credit_sum: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(r_credits) + int'(w_fifo_count)) <= DEPTH);
  a_full_no_credit: assert property (@(posedge clk) disable iff (!rst_n)
    w_fifo_full |-> (r_credits == '0));

endmodule

// File: tb/tb_counter_chain_arbiter.sv
// tb/tb_counter_chain_arbiter.sv - randomized self-checking bench for counter_chain_arbiter
module tb_counter_chain_arbiter;
  import counter_chain_pkg::*;

  localparam int NREQ   = 4;
  localparam int LENGTH = 8;
  localparam int LAT    = 1;
  localparam int DEPTH  = 4;
  localparam int OWD    = 2 * LENGTH + 3;
  localparam int IDW    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NREQ-1:0]          req_valid = '0;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*5*LENGTH-1:0] req_ops = '0;
  logic [NREQ*6-1:0]        req_cin = '0;
`ifdef COUNTER_CHAIN_ARB_LOCK_EN
  logic [NREQ-1:0]          req_lock = '0;
`endif
  logic [LENGTH-1:0]        ch_cl00, ch_cl01, ch_cl02, ch_cl03, ch_cl10;
  logic [4:0]               ch_c0;
  logic                     ch_c1;
  logic [OWD-1:0]           ch_o = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [IDW-1:0]           rsp_id;
  logic [OWD-1:0]           rsp_data;

  always #5 clk = ~clk;

  counter_chain_arbiter #(.NREQ(NREQ), .LENGTH(LENGTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops), .req_cin(req_cin),
`ifdef COUNTER_CHAIN_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .ch_cl00(ch_cl00), .ch_cl01(ch_cl01), .ch_cl02(ch_cl02), .ch_cl03(ch_cl03),
    .ch_cl10(ch_cl10), .ch_c0(ch_c0), .ch_c1(ch_c1), .ch_o(ch_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Stand-in compressor: weighted sum of the column groups plus the tail bits.
  function automatic logic [OWD-1:0] chain_fn(input cc_fields_t f);
    return OWD'(f.cl00) + OWD'(f.cl01) + OWD'(f.cl02) + OWD'(f.cl03)
         + (OWD'(f.cl10) << LENGTH) + OWD'(f.c0) + OWD'(f.c1);
  endfunction

  cc_fields_t ch_f;
  assign ch_f = {ch_cl10, ch_cl03, ch_cl02, ch_cl01, ch_cl00, ch_c1, ch_c0};
  always @(posedge clk) ch_o <= chain_fn(ch_f);

  longint cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Reference model: pending results in issue order, each visible from cycle t.
  typedef struct {
    int             id;
    logic [OWD-1:0] data;
    longint         t;
  } exp_t;

  cc_fields_t         fld [NREQ];
  exp_t               m_q [$];
  int                 m_rr;
  int                 m_credits;
  int                 exp_g;
  logic [NREQ-1:0]    exp_ready;
  cc_fields_t         exp_ch;
  logic               exp_rv;
  logic [IDW+OWD-1:0] exp_rsp;
  int                 n_checks = 0;
  int                 n_errors = 0;

  task automatic model_reset();
    m_rr      = 0;
    m_credits = DEPTH;
    m_q.delete();
  endtask

  // Drives one cycle at the negedge, then predicts this cycle's outputs and
  // advances the model as of the following posedge.
  task automatic run_cycle(input logic [NREQ-1:0] v, input logic rr, input bit rand_fields);
    logic [63:0] r64;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (rand_fields) begin
        r64    = {$urandom, $urandom};
        fld[i] = r64[$bits(cc_fields_t)-1:0];
      end
      req_ops[i*5*LENGTH +: 5*LENGTH] = {fld[i].cl10, fld[i].cl03, fld[i].cl02, fld[i].cl01, fld[i].cl00};
      req_cin[i*6 +: 6] = {fld[i].c1, fld[i].c0};
    end
    req_valid = v;
    rsp_ready = rr;
    #1;
    exp_g = -1;
    if (m_credits > 0)
      for (int k = 0; k < NREQ; k++)
        if (exp_g < 0 && v[(m_rr + k) % NREQ]) exp_g = (m_rr + k) % NREQ;
    exp_ready = '0;
    exp_ch    = '0;
    if (exp_g >= 0) begin
      exp_ready[exp_g] = 1'b1;
      exp_ch = fld[exp_g];
    end
    exp_rv  = (m_q.size() > 0) && (m_q[0].t <= cyc_now);
    exp_rsp = exp_rv ? {IDW'(m_q[0].id), m_q[0].data} : '0;
    if (exp_rv && rr) begin
      void'(m_q.pop_front());
      m_credits++;
    end
    if (exp_g >= 0) begin
      m_q.push_back('{id: exp_g, data: chain_fn(fld[exp_g]), t: cyc_now + LAT + 1});
      m_credits--;
      m_rr = (exp_g + 1) % NREQ;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    n_checks += 3;
    if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset.rsp_valid got=%b exp=0", rsp_valid); end
    if (req_ready !== '0) begin n_errors++; $display("FAIL reset.req_ready got=%b exp=0000", req_ready); end
    if (ch_f !== '0) begin n_errors++; $display("FAIL reset.ch got=%h exp=0", ch_f); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] oh;
    for (int i = 0; i < 16; i++) begin
      run_cycle((i < 12) ? '1 : '0, 1'b1, 1'b1);
      n_checks += 3;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rr.ready t=%0d got=%b exp=%b", cyc_now, req_ready, exp_ready); end
      if (ch_f !== exp_ch) begin n_errors++; $display("FAIL rr.ch t=%0d got=%h exp=%h", cyc_now, ch_f, exp_ch); end
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_rsp))
        begin n_errors++; $display("FAIL rr.rsp t=%0d got=%b/%h exp=%b/%h", cyc_now, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_rsp); end
      if (i < 12) begin
        oh = NREQ'(1) << (i % NREQ);
        n_checks++;
        if (req_ready !== oh) begin n_errors++; $display("FAIL rr.order i=%0d got=%b exp=%b", i, req_ready, oh); end
      end
      if (i < 3) begin
        n_checks++;
        if (rsp_valid !== (i == 2)) begin n_errors++; $display("FAIL rr.first_rsp i=%0d got=%b exp=%b", i, rsp_valid, i == 2); end
      end
    end
  endtask

  task automatic test_single_req2();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) fld[i] = '0;
    fld[2].cl00 = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      v = (i < 6 && i % 2 == 0) ? 4'b0100 : 4'b0000;
      run_cycle(v, 1'b1, 1'b0);
      n_checks += 4;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL req2.ready t=%0d got=%b exp=%b", cyc_now, req_ready, exp_ready); end
      if (ch_f !== exp_ch) begin n_errors++; $display("FAIL req2.ch t=%0d got=%h exp=%h", cyc_now, ch_f, exp_ch); end
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_rsp))
        begin n_errors++; $display("FAIL req2.rsp t=%0d got=%b/%h exp=%b/%h", cyc_now, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_rsp); end
      if (v != 0) begin
        if (ch_cl00 !== 8'h0F) begin n_errors++; $display("FAIL req2.cl00 got=%h exp=0f", ch_cl00); end
      end else begin
        if (ch_f !== '0) begin n_errors++; $display("FAIL req2.idle_ch got=%h exp=0", ch_f); end
      end
      if (rsp_valid) begin
        n_checks++;
        if (rsp_id !== 2'd2 || rsp_data !== OWD'(8'h0F))
          begin n_errors++; $display("FAIL req2.result got=%0d/%h exp=2/%h", rsp_id, rsp_data, OWD'(8'h0F)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n1, n2;
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) run_cycle('1, 1'b0, 1'b1);
      else if (i == 8) run_cycle('1, 1'b1, 1'b1);
      else run_cycle('1, 1'b0, 1'b1);
      n_checks += 3;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL bp.ready t=%0d got=%b exp=%b", cyc_now, req_ready, exp_ready); end
      if (ch_f !== exp_ch) begin n_errors++; $display("FAIL bp.ch t=%0d got=%h exp=%h", cyc_now, ch_f, exp_ch); end
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_rsp))
        begin n_errors++; $display("FAIL bp.rsp t=%0d got=%b/%h exp=%b/%h", cyc_now, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_rsp); end
      if (req_ready != 0) begin
        if (i < 8) n1++;
        else n2++;
      end
    end
    n_checks += 2;
    if (n1 != DEPTH) begin n_errors++; $display("FAIL bp.issues_stalled got=%0d exp=%0d", n1, DEPTH); end
    if (n2 != 1) begin n_errors++; $display("FAIL bp.issues_after_pop got=%0d exp=1", n2); end
    for (int i = 0; i < 8; i++) begin
      run_cycle('0, 1'b1, 1'b1);
      n_checks++;
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_rsp))
        begin n_errors++; $display("FAIL bp.drain t=%0d got=%b/%h exp=%b/%h", cyc_now, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_rsp); end
    end
  endtask

  task automatic test_fifo_wrap();
    int   iq [$];
    int   gq [$];
    int   n_iss, n_cyc;
    logic tog;
    bit   same;
    n_iss = 0;
    n_cyc = 0;
    tog   = 1'b0;
    while ((n_iss < 20 || m_q.size() > 0) && n_cyc < 400) begin
      tog = ~tog;
      run_cycle((n_iss < 20) ? NREQ'($urandom) : '0, tog, 1'b1);
      n_cyc++;
      n_checks += 3;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL wrap.ready t=%0d got=%b exp=%b", cyc_now, req_ready, exp_ready); end
      if (ch_f !== exp_ch) begin n_errors++; $display("FAIL wrap.ch t=%0d got=%h exp=%h", cyc_now, ch_f, exp_ch); end
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_rsp))
        begin n_errors++; $display("FAIL wrap.rsp t=%0d got=%b/%h exp=%b/%h", cyc_now, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_rsp); end
      for (int b = 0; b < NREQ; b++) if (req_ready[b]) begin iq.push_back(b); n_iss++; end
      if (rsp_valid && rsp_ready) gq.push_back(int'(rsp_id));
    end
    same = (iq.size() == gq.size());
    if (same) for (int i = 0; i < iq.size(); i++) if (iq[i] != gq[i]) same = 0;
    n_checks += 3;
    if (n_cyc >= 400) begin n_errors++; $display("FAIL wrap.timeout cycles=%0d limit=400", n_cyc); end
    if (gq.size() != 20) begin n_errors++; $display("FAIL wrap.count got=%0d exp=20", gq.size()); end
    if (!same) begin n_errors++; $display("FAIL wrap.order got_len=%0d exp_len=%0d", gq.size(), iq.size()); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      run_cycle('1, 1'b0, 1'b1);
      n_checks++;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rstmid.ready t=%0d got=%b exp=%b", cyc_now, req_ready, exp_ready); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid.rsp_valid got=%b exp=0", rsp_valid); end
    if (req_ready !== '0) begin n_errors++; $display("FAIL rstmid.req_ready got=%b exp=0000", req_ready); end
    model_reset();
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_cycle((i == 5) ? '1 : '0, 1'b1, 1'b1);
      n_checks += 2;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rstmid.post_ready t=%0d got=%b exp=%b", cyc_now, req_ready, exp_ready); end
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_rsp))
        begin n_errors++; $display("FAIL rstmid.post_rsp t=%0d got=%b/%h exp=%b/%h", cyc_now, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_rsp); end
      if (i == 5) begin
        n_checks++;
        if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rstmid.rr_ptr got=%b exp=0001", req_ready); end
      end
    end
  endtask

`ifdef COUNTER_CHAIN_ARB_LOCK_EN
  task automatic test_lock();
    logic [NREQ-1:0] vs [5];
    logic [NREQ-1:0] ls [5];
    logic [NREQ-1:0] gs [5];
    vs = '{4'b0010, 4'b1011, 4'b1011, 4'b1001, 4'b1001};
    ls = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    gs = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = vs[i];
      req_lock  = ls[i];
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== gs[i]) begin n_errors++; $display("FAIL lock.grant i=%0d got=%b exp=%b", i, req_ready, gs[i]); end
    end
    @(negedge clk);
    req_valid = '0;
    req_lock  = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_single_req2();
    test_backpressure();
    test_fifo_wrap();
    test_reset_mid();
`ifdef COUNTER_CHAIN_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
